// File: rtl/instruction_fetch.sv
// Fetch stage: 2^ADDR_W x 16 instruction store, run/halt FSM,
// JMP/HALT handling and registered field outputs with stall hold.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   start, stall              : begin fetch at 0, downstream hold
//   prog_we/prog_addr/prog_data: instruction store write (idle/halted)
//   Opcode, Rd, Rs, Rt        : registered instruction fields
//   instr_valid, pc, halted   : valid flag, next fetch address, halted
module instruction_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [3:0]        Opcode,
  output logic [2:0]        Rd,
  output logic [2:0]        Rs,
  output logic [2:0]        Rt,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [3:0] OP_JMP  = 4'he;
  localparam logic [3:0] OP_HALT = 4'hf;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t state_q, state_d;

  logic [15:0] mem [2**ADDR_W];
  logic [15:0] word;

  logic [ADDR_W-1:0] pc_d;
  logic [3:0]        op_d;
  logic [2:0]        rd_d, rs_d, rt_d;
  logic              valid_d;
  logic              is_jmp, is_halt;

  // Memory is deliberately left out of reset so a program
  // survives a reset and can be rerun.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && state_q != RUN)
      mem[prog_addr] <= prog_data;
  end

  assign word    = mem[pc];
  assign is_jmp  = word[15:12] == OP_JMP;
  assign is_halt = word[15:12] == OP_HALT;
  assign halted  = state_q == HALTED;

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    op_d    = Opcode;
    rd_d    = Rd;
    rs_d    = Rs;
    rt_d    = Rt;
    valid_d = instr_valid;
    unique case (state_q)
      IDLE, HALTED: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          {op_d, rd_d, rs_d, rt_d} = word[15:3];
          unique case (1'b1)
            is_jmp: begin
              pc_d    = word[ADDR_W-1:0];
              valid_d = 1'b0;
            end
            // pc stays on the HALT word
            is_halt: begin
              state_d = HALTED;
              valid_d = 1'b0;
            end
            default: begin
              pc_d    = pc + ADDR_W'(1);
              valid_d = 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc          <= '0;
      Opcode      <= '0;
      Rd          <= '0;
      Rs          <= '0;
      Rt          <= '0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      Opcode      <= op_d;
      Rd          <= rd_d;
      Rs          <= rs_d;
      Rt          <= rt_d;
      instr_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus
// randomized traffic against a word-level reference model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [3:0]  Opcode;
  logic [2:0]  Rd, Rs, Rt;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;

  instruction_fetch #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Opcode(Opcode), .Rd(Rd), .Rs(Rs),
    .Rt(Rt), .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  wire [22:0] obs = {Opcode, Rd, Rs, Rt, instr_valid, pc, halted};

  // Model: mode 0 idle, 1 run, 2 halted; m_w is last word loaded.
  logic [15:0] m_mem [256];
  int          m_mode = 0;
  int          m_pc = 0;
  logic [15:0] m_w = '0;
  bit          m_v = 1'b0;

  function automatic logic [22:0] expv();
    logic [7:0] p;
    p = m_pc[7:0];
    return {m_w[15:3], m_v, p, m_mode == 2};
  endfunction

  function automatic void model_step();
    if (reset) begin
      m_mode = 0; m_pc = 0; m_w = '0; m_v = 1'b0;
    end else if (m_mode != 1) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (start) begin m_mode = 1; m_pc = 0; end
    end else if (!stall) begin
      m_w = m_mem[m_pc];
      if (m_w[15:12] == 4'd14) begin
        m_pc = int'(m_w[7:0]); m_v = 1'b0;
      end else if (m_w[15:12] == 4'd15) begin
        m_mode = 2; m_v = 1'b0;
      end else begin
        m_pc = (m_pc + 1) % 256; m_v = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_all();
    for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++;
      $display("FAIL load_idle got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_basic();
    load(8'd0, 16'h1298);
    load(8'd1, 16'hF000);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++;
      $display("FAIL basic_c1 got=%h want=%h", obs, expv());
    end
    tick();
    n_cmp++;
    if ({Opcode, Rd, Rs, Rt, instr_valid} !==
        {4'd1, 3'd1, 3'd2, 3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL basic_first got=%h want=%h",
               {Opcode, Rd, Rs, Rt, instr_valid},
               {4'd1, 3'd1, 3'd2, 3'd3, 1'b1});
    end
    tick();
    n_cmp++;
    if ({instr_valid, halted, pc} !== {1'b0, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL basic_halt got=%h want=%h",
               {instr_valid, halted, pc}, {1'b0, 1'b1, 8'd1});
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_q[$];
    logic [12:0] got_q[$];
    logic [15:0] w;
    int cyc;
    for (int i = 0; i < 10; i++) begin
      w = {4'($urandom_range(0, 13)), 12'($urandom)};
      exp_q.push_back(w);
      load(8'(i), w);
    end
    load(8'd10, 16'hF000);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 40) begin
      stall = (cyc >= 5 && cyc <= 7);
      tick();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL stall_cyc%0d got=%h want=%h",
                 cyc, obs, expv());
      end
      if (!stall && instr_valid)
        got_q.push_back({Opcode, Rd, Rs, Rt});
      cyc++;
    end
    stall = 1'b0;
    n_cmp++;
    if (!halted || got_q.size() != 10) begin
      n_bad++;
      $display("FAIL stall_stream got=%0d want=10 halted=%b",
               got_q.size(), halted);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i][15:3]) begin
          n_bad++;
          $display("FAIL stall_word%0d got=%h want=%h",
                   i, got_q[i], exp_q[i][15:3]);
        end
      end
    end
  endtask

  task automatic test_jmp();
    load(8'd0, 16'h1000);
    load(8'd1, 16'h3000);
    load(8'd2, 16'hE005);
    load(8'd3, 16'h7000);
    load(8'd4, 16'h7000);
    load(8'd5, 16'h2000);
    load(8'd6, 16'hF000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL jmp_pre%0d got=%h want=%h", i, obs, expv());
      end
    end
    n_cmp++;
    if ({instr_valid, pc} !== {1'b0, 8'd5}) begin
      n_bad++;
      $display("FAIL jmp_bubble got=%h want=%h",
               {instr_valid, pc}, {1'b0, 8'd5});
    end
    tick();
    n_cmp++;
    if ({Opcode, instr_valid, pc} !== {4'd2, 1'b1, 8'd6}) begin
      n_bad++;
      $display("FAIL jmp_target got=%h want=%h",
               {Opcode, instr_valid, pc}, {4'd2, 1'b1, 8'd6});
    end
    tick();
  endtask

  task automatic test_wrap_reset();
    load(8'd0, 16'hE0FF);
    load(8'd255, 16'h3ABC);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({instr_valid, pc} !== {1'b0, 8'hFF}) begin
      n_bad++;
      $display("FAIL wrap_jmp got=%h want=%h",
               {instr_valid, pc}, {1'b0, 8'hFF});
    end
    tick();
    n_cmp++;
    if ({Opcode, instr_valid, pc} !== {4'd3, 1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL wrap_pc got=%h want=%h",
               {Opcode, instr_valid, pc}, {4'd3, 1'b1, 8'd0});
    end
    reset = 1'b1;
    start = 1'b1;
    prog_we = 1'b1;
    prog_addr = 8'd0;
    prog_data = 16'h4444;
    tick();
    reset = 1'b0;
    start = 1'b0;
    prog_we = 1'b0;
    n_cmp++;
    if (obs !== 23'd0) begin
      n_bad++;
      $display("FAIL midrun_reset got=%h want=0", obs);
    end
  endtask

  task automatic test_run_write();
    load(8'd0, 16'h1111);
    load(8'd1, 16'hF000);
    start = 1'b1;
    tick();
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h7777;
    tick();
    prog_we = 1'b0;
    tick();
    n_cmp++;
    if (halted !== 1'b1) begin
      n_bad++;
      $display("FAIL runwr_halt got=%b want=1", halted);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({Opcode, instr_valid} !== {4'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL runwr_mem got=%h want=%h",
               {Opcode, instr_valid}, {4'd1, 1'b1});
    end
    tick();
  endtask

  task automatic test_prog_start();
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h5ABC;
    start = 1'b1;
    stall = 1'b1;
    tick();
    prog_we = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    n_cmp++;
    if ({halted, instr_valid, pc} !== {1'b0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL pstart_run got=%h want=0",
               {halted, instr_valid, pc});
    end
    tick();
    n_cmp++;
    if ({Opcode, instr_valid} !== {4'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL pstart_word got=%h want=%h",
               {Opcode, instr_valid}, {4'd5, 1'b1});
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      start     = ($urandom_range(0, 5) == 0);
      stall     = ($urandom_range(0, 2) == 0);
      prog_we   = ($urandom_range(0, 2) == 0);
      prog_addr = 8'($urandom_range(0, 15));
      prog_data = 16'($urandom);
      tick();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL random_%0d got=%h want=%h", i, obs, expv());
      end
    end
    reset = 1'b0; start = 1'b0; stall = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_all();
    test_basic();
    test_stall();
    test_jmp();
    test_wrap_reset();
    test_run_write();
    test_prog_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
